// File: rtl/err_scan_pkg.sv
// ---------------------------------------------------------------------------
// err_scan_pkg
// Shared definitions for the error-detector scan controller:
//   - state_e        : scheduler states (idle, flush, scan, capture, next)
//   - DEFAULT_*      : default channel count, window length and flush length
//   - ch_idx_w()     : width of a channel index for a given channel count
// ---------------------------------------------------------------------------
package err_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_SCAN,
    ST_CAPTURE,
    ST_NEXT
  } state_e;

  localparam int DEFAULT_CH    = 4;
  localparam int DEFAULT_WIN   = 64;
  localparam int DEFAULT_FLUSH = 2;

  // A channel index is never narrower than one bit.
  function automatic int ch_idx_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/err_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// err_scan_ctrl_if
// Status-clear handshake between software (master) and the scan controller
// (slave).
//   clr_valid : master -> slave, clear request
//   clr_ch    : master -> slave, channel whose sticky flags are cleared
//   clr_ready : slave -> master, request accepted in this cycle
// ---------------------------------------------------------------------------
interface err_scan_ctrl_if
  import err_scan_pkg::*;
#(
  parameter int CH = DEFAULT_CH
) ();

  localparam int CW = ch_idx_w(CH);

  logic          clr_valid;
  logic [CW-1:0] clr_ch;
  logic          clr_ready;

  modport master (output clr_valid, output clr_ch, input clr_ready);
  modport slave  (input clr_valid, input clr_ch, output clr_ready);

endinterface

// File: rtl/err_scan_rr_ptr.sv
// ---------------------------------------------------------------------------
// err_scan_rr_ptr
// Round-robin channel pointer. Holds the channel that currently owns the
// detector and moves to the next channel when 'advance' is high.
// Optional feature (macro ERR_SCAN_MASK_EN): the pointer skips channels whose
// ch_mask bit is 0; with an all-zero mask it holds its value.
//   clock, reset : clock and asynchronous active-low reset
//   advance      : move to the next channel at the next rising edge
//   ch_mask      : (ERR_SCAN_MASK_EN only) per-channel scan enable
//   cur_ch       : current channel index
// ---------------------------------------------------------------------------
module err_scan_rr_ptr
  import err_scan_pkg::*;
#(
  parameter int CH = DEFAULT_CH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     advance,
`ifdef ERR_SCAN_MASK_EN
  input  logic [CH-1:0]            ch_mask,
`endif
  output logic [ch_idx_w(CH)-1:0]  cur_ch
);

  localparam int CW = ch_idx_w(CH);

  logic [CW-1:0] cur_ch_q;
  logic [CW-1:0] cur_ch_d;
  logic [CW-1:0] nxt_ch;
`ifdef ERR_SCAN_MASK_EN
  logic [CW:0]   probe;
`endif

  always_comb begin
`ifdef ERR_SCAN_MASK_EN
    // Walk offsets from farthest to nearest so the nearest enabled channel
    // after the current one is the last assignment. Offset CH lands back on
    // the current channel, so a single enabled channel keeps being scanned.
    nxt_ch = cur_ch_q;
    probe  = '0;
    for (int i = CH; i >= 1; i--) begin
      probe = {1'b0, cur_ch_q} + (CW+1)'(i);
      if (probe >= (CW+1)'(CH)) begin
        probe = probe - (CW+1)'(CH);
      end
      if (ch_mask[probe[CW-1:0]]) begin
        nxt_ch = probe[CW-1:0];
      end
    end
`else
    // Explicit wrap so non-power-of-two channel counts never leave range.
    nxt_ch = (cur_ch_q == CW'(CH-1)) ? '0 : cur_ch_q + CW'(1);
`endif
    cur_ch_d = advance ? nxt_ch : cur_ch_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_ch_q <= '0;
    end else begin
      cur_ch_q <= cur_ch_d;
    end
  end

  assign cur_ch = cur_ch_q;

endmodule

// File: rtl/err_scan_ctrl.sv
// ---------------------------------------------------------------------------
// err_scan_ctrl
// Time-shares a single error detector among CH serial channels. Each window
// holds the detector in reset for FLUSH cycles, streams WIN samples of the
// current channel, captures warning/error into sticky per-channel flags and
// moves to the next channel. irq reports any set error flag (and warning flag
// when WARN_IRQ=1); software clears flags through the clr_if handshake.
// Optional feature (macro ERR_SCAN_MASK_EN): adds ch_mask, and only channels
// with a set mask bit are scanned; an all-zero mask parks the block in idle.
// Ports:
//   clock, reset            : clock, asynchronous active-low reset
//   enable                  : scanning allowed
//   ch_in                   : one serial data bit per channel
//   ch_mask                 : (ERR_SCAN_MASK_EN only) per-channel scan enable
//   det_in, det_reset       : sample and active-high reset to the detector
//   det_warning, det_error  : detector results
//   cur_ch                  : channel currently owning the detector
//   warn_status, err_status : sticky per-channel flags
//   irq                     : interrupt
//   clr_if                  : clear handshake (slave side)
// ---------------------------------------------------------------------------
module err_scan_ctrl
  import err_scan_pkg::*;
#(
  parameter int CH       = DEFAULT_CH,
  parameter int WIN      = DEFAULT_WIN,
  parameter int FLUSH    = DEFAULT_FLUSH,
  parameter int WARN_IRQ = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [CH-1:0]            ch_in,
`ifdef ERR_SCAN_MASK_EN
  input  logic [CH-1:0]            ch_mask,
`endif
  output logic                     det_in,
  output logic                     det_reset,
  input  logic                     det_warning,
  input  logic                     det_error,
  output logic [ch_idx_w(CH)-1:0]  cur_ch,
  output logic [CH-1:0]            warn_status,
  output logic [CH-1:0]            err_status,
  output logic                     irq,
  err_scan_ctrl_if.slave           clr_if
);

  localparam int FW = (FLUSH > 1) ? $clog2(FLUSH) : 1;
  localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;

  state_e        state_q, state_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [CH-1:0] warn_q, warn_d;
  logic [CH-1:0] err_q, err_d;
  logic          irq_q, irq_d;
  logic          det_in_q, det_in_d;
  logic          clr_ready_q, clr_ready_d;
  logic          advance;
  logic          any_en;
  logic          cur_en;
  logic          clr_fire;

  err_scan_rr_ptr #(
    .CH      (CH)
  ) u_rr_ptr (
    .clock   (clock),
    .reset   (reset),
    .advance (advance),
`ifdef ERR_SCAN_MASK_EN
    .ch_mask (ch_mask),
`endif
    .cur_ch  (cur_ch)
  );

`ifdef ERR_SCAN_MASK_EN
  assign any_en = |ch_mask;
  assign cur_en = ch_mask[cur_ch];
`else
  assign any_en = 1'b1;
  assign cur_en = 1'b1;
`endif

  assign clr_fire = clr_if.clr_valid & clr_ready_q;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = '0;
    win_cnt_d   = '0;
    warn_d      = warn_q;
    err_d       = err_q;
    advance     = 1'b0;

    // Clear is applied first so a capture in the same cycle would win; in
    // practice clr_ready is low during capture so the two never coincide.
    if (clr_fire && (int'(clr_if.clr_ch) < CH)) begin
      warn_d[clr_if.clr_ch] = 1'b0;
      err_d[clr_if.clr_ch]  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable && any_en) begin
          state_d = ST_FLUSH;
          // A masked-off parked channel is skipped before its window starts.
          advance = !cur_en;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FW'(FLUSH-1)) begin
          state_d = ST_SCAN;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      ST_SCAN: begin
        if (win_cnt_q == WW'(WIN-1)) begin
          state_d = ST_CAPTURE;
        end else begin
          win_cnt_d = win_cnt_q + WW'(1);
        end
      end
      ST_CAPTURE: begin
        warn_d[cur_ch] = warn_q[cur_ch] | det_warning;
        err_d[cur_ch]  = err_q[cur_ch] | det_error;
        state_d        = ST_NEXT;
      end
      ST_NEXT: begin
        advance = 1'b1;
        state_d = (enable && any_en) ? ST_FLUSH : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Loading the sample whenever the next state is SCAN lines the WIN
    // samples up exactly with the WIN scan cycles and leaves det_in low
    // during capture.
    det_in_d    = (state_d == ST_SCAN) ? ch_in[cur_ch] : 1'b0;
    clr_ready_d = (state_d != ST_CAPTURE);
    irq_d       = (|err_q) | ((WARN_IRQ != 0) & (|warn_q));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      win_cnt_q   <= '0;
      warn_q      <= '0;
      err_q       <= '0;
      irq_q       <= 1'b0;
      det_in_q    <= 1'b0;
      clr_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      win_cnt_q   <= win_cnt_d;
      warn_q      <= warn_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
      det_in_q    <= det_in_d;
      clr_ready_q <= clr_ready_d;
    end
  end

  // Decoded straight from the state register so it rises together with the
  // asynchronous reset.
  assign det_reset        = (state_q != ST_SCAN) && (state_q != ST_CAPTURE);
  assign det_in           = det_in_q;
  assign warn_status      = warn_q;
  assign err_status       = err_q;
  assign irq              = irq_q;
  assign clr_if.clr_ready = clr_ready_q;

endmodule

// File: tb/tb_err_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_err_scan_ctrl
// Scoreboard bench for err_scan_ctrl (CH=4, WIN=64, FLUSH=2, WARN_IRQ=0).
// The stimulus process pushes the expected outcome of every scan window; the
// monitor recognises the end of a window (det_reset rising while out of
// reset) and compares channel, sticky flags, irq timing and window length.
// A simple detector model raises det_error/det_warning for flagged channels
// while the detector is out of reset. With ERR_SCAN_MASK_EN defined the
// masked scan order is exercised as well.
// ---------------------------------------------------------------------------
module tb_err_scan_ctrl;

  localparam int CH    = 4;
  localparam int WIN   = 64;
  localparam int FLUSH = 2;

  typedef struct {
    int         ch;
    logic [3:0] warn;
    logic [3:0] err;
    logic       irq_now;
    logic       irq_next;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [3:0] ch_in;
  logic       det_in;
  logic       det_reset;
  logic       det_warning;
  logic       det_error;
  logic [1:0] cur_ch;
  logic [3:0] warn_status;
  logic [3:0] err_status;
  logic       irq;
  logic [3:0] flag_err;
  logic [3:0] flag_warn;
`ifdef ERR_SCAN_MASK_EN
  logic [3:0] ch_mask;
`endif

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb_q[$];

  err_scan_ctrl_if #(.CH(CH)) clr_if ();

  err_scan_ctrl #(
    .CH          (CH),
    .WIN         (WIN),
    .FLUSH       (FLUSH),
    .WARN_IRQ    (0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .ch_in       (ch_in),
`ifdef ERR_SCAN_MASK_EN
    .ch_mask     (ch_mask),
`endif
    .det_in      (det_in),
    .det_reset   (det_reset),
    .det_warning (det_warning),
    .det_error   (det_error),
    .cur_ch      (cur_ch),
    .warn_status (warn_status),
    .err_status  (err_status),
    .irq         (irq),
    .clr_if      (clr_if)
  );

  // Detector model: a flagged channel reports while the detector runs.
  assign det_error   = ~det_reset & flag_err[cur_ch];
  assign det_warning = ~det_reset & flag_warn[cur_ch];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Inputs change and outputs are sampled 2 time units after a rising edge.
  task automatic apply_stimulus(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic push_exp(input int ch, input logic [3:0] w, input logic [3:0] e,
                          input logic irq_now, input logic irq_next);
    exp_t x;
    x.ch = ch; x.warn = w; x.err = e; x.irq_now = irq_now; x.irq_next = irq_next;
    sb_q.push_back(x);
  endtask

  task automatic wait_cur_ch(input int ch, input int budget);
    int n = 0;
    while (int'(cur_ch) != ch && n < budget) begin
      apply_stimulus(1);
      n++;
    end
    if (int'(cur_ch) != ch) timeout_fail("wait_cur_ch");
  endtask

  task automatic wait_det_reset(input logic val, input int budget);
    int n = 0;
    while (det_reset !== val && n < budget) begin
      apply_stimulus(1);
      n++;
    end
    if (det_reset !== val) timeout_fail("wait_det_reset");
  endtask

  task automatic wait_sb_empty(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      apply_stimulus(1);
      n++;
    end
    if (sb_q.size() != 0) timeout_fail("wait_scoreboard_empty");
  endtask

  // Monitor: a window ends in the NEXT cycle, seen as det_reset rising while
  // out of reset. The previous cycle was CAPTURE.
  int   low_cnt;
  logic prev_det_reset;
  logic prev_clr_ready;
  logic irq_pending;
  logic exp_irq_next;
  exp_t mon_e;

  always @(negedge clock) begin
    if (!reset) begin
      low_cnt        = 0;
      prev_det_reset = 1'b1;
      prev_clr_ready = 1'b0;
      irq_pending    = 1'b0;
    end else begin
      if (irq_pending) begin
        check_output("irq_after_capture", irq, exp_irq_next);
        irq_pending = 1'b0;
      end
      if (!det_reset) begin
        low_cnt++;
      end else if (!prev_det_reset) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_window: got channel %0d expected no window", cur_ch);
        end else begin
          mon_e = sb_q.pop_front();
          check_output("window_channel", cur_ch, mon_e.ch);
          check_output("warn_status", warn_status, mon_e.warn);
          check_output("err_status", err_status, mon_e.err);
          check_output("irq_in_next", irq, mon_e.irq_now);
          check_output("window_length", low_cnt, WIN + 1);
          check_output("clr_ready_in_capture", prev_clr_ready, 1'b0);
          check_output("clr_ready_in_next", clr_if.clr_ready, 1'b1);
          exp_irq_next = mon_e.irq_next;
          irq_pending  = 1'b1;
        end
        low_cnt = 0;
      end
      prev_det_reset = det_reset;
      prev_clr_ready = clr_if.clr_ready;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] pat;
    logic        b;
    int          t1;
    int          lows;

    pat       = 32'hA5C3_9E1B;
    reset     = 1'b0;
    enable    = 1'b0;
    ch_in     = 4'b0000;
    flag_err  = 4'b0000;
    flag_warn = 4'b0000;
    clr_if.clr_valid = 1'b0;
    clr_if.clr_ch    = 2'd0;
`ifdef ERR_SCAN_MASK_EN
    ch_mask   = 4'b1111;
`endif
    apply_stimulus(3);

    $display("[TB] reset values");
    check_output("rst_cur_ch", cur_ch, 0);
    check_output("rst_det_in", det_in, 0);
    check_output("rst_det_reset", det_reset, 1);
    check_output("rst_status", {warn_status, err_status}, 0);
    check_output("rst_irq", irq, 0);
    check_output("rst_clr_ready", clr_if.clr_ready, 0);

    $display("[TB] free-running scan, no flags");
    enable = 1'b1;
    reset  = 1'b1;
    for (int c = 0; c < CH; c++) push_exp(c, 4'b0000, 4'b0000, 1'b0, 1'b0);
    wait_cur_ch(1, 200);
    t1 = cyc;
    wait_cur_ch(2, 200);
    check_output("window_period", cyc - t1, FLUSH + WIN + 2);
    wait_sb_empty(400);

    $display("[TB] error on channel 2");
    flag_err[2] = 1'b1;
    push_exp(0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    push_exp(1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    push_exp(2, 4'b0000, 4'b0100, 1'b0, 1'b1);
    wait_sb_empty(400);
    flag_err = 4'b0000;

    $display("[TB] clear channel 2");
    wait_det_reset(1'b0, 20);
    apply_stimulus(3);
    clr_if.clr_ch    = 2'd2;
    clr_if.clr_valid = 1'b1;
    check_output("clr_ready_in_scan", clr_if.clr_ready, 1);
    apply_stimulus(1);
    clr_if.clr_valid = 1'b0;
    check_output("err_after_clear", err_status, 4'b0000);
    check_output("irq_still_set", irq, 1);
    apply_stimulus(1);
    check_output("irq_after_clear", irq, 0);
    push_exp(3, 4'b0000, 4'b0000, 1'b0, 1'b0);
    wait_sb_empty(200);

    $display("[TB] enable drop mid-window on channel 1");
    push_exp(0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    wait_cur_ch(1, 200);
    wait_det_reset(1'b0, 10);
    for (int i = 0; i < 30; i++) begin
      b     = pat[i];
      ch_in = b ? 4'b0010 : 4'b1101;
      apply_stimulus(1);
      check_output("det_in_latency", det_in, b);
    end
    enable = 1'b0;
    ch_in  = 4'b0000;
    push_exp(1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    wait_sb_empty(100);
    apply_stimulus(2);
    check_output("parked_cur_ch", cur_ch, 2);
    check_output("parked_det_reset", det_reset, 1);
    check_output("parked_det_in", det_in, 0);
    lows = 0;
    repeat (20) begin
      apply_stimulus(1);
      if (!det_reset) lows++;
    end
    check_output("parked_stays_idle", lows, 0);

    $display("[TB] asynchronous reset mid-window on channel 3");
    flag_err[2] = 1'b1;
    enable      = 1'b1;
    push_exp(2, 4'b0000, 4'b0100, 1'b0, 1'b1);
    wait_cur_ch(3, 100);
    flag_err = 4'b0000;
    wait_det_reset(1'b0, 10);
    apply_stimulus(10);
    #1;
    reset = 1'b0;
    #1;
    check_output("async_det_reset", det_reset, 1);
    check_output("async_err_status", err_status, 4'b0000);
    check_output("async_irq", irq, 0);
    check_output("async_cur_ch", cur_ch, 0);
    check_output("async_clr_ready", clr_if.clr_ready, 0);
    apply_stimulus(2);
    flag_warn[0] = 1'b1;
    reset = 1'b1;
    apply_stimulus(1);
    check_output("release_cur_ch", cur_ch, 0);
    push_exp(0, 4'b0001, 4'b0000, 1'b0, 1'b0);
    wait_sb_empty(200);
    flag_warn = 4'b0000;

`ifdef ERR_SCAN_MASK_EN
    $display("[TB] masked scan 1010 then empty mask");
    reset = 1'b0;
    apply_stimulus(2);
    ch_mask = 4'b1010;
    reset   = 1'b1;
    push_exp(1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    push_exp(3, 4'b0000, 4'b0000, 1'b0, 1'b0);
    push_exp(1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    wait_cur_ch(1, 20);
    wait_cur_ch(3, 200);
    wait_cur_ch(1, 200);
    ch_mask = 4'b0000;
    wait_sb_empty(200);
    apply_stimulus(2);
    check_output("mask_empty_det_reset", det_reset, 1);
    check_output("mask_empty_cur_ch", cur_ch, 1);
    lows = 0;
    repeat (100) begin
      apply_stimulus(1);
      if (!det_reset) lows++;
    end
    check_output("mask_empty_idle", lows, 0);
`endif

    apply_stimulus(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/err_scan_ctrl.md
Name: err_scan_ctrl

Overview:
- Time-shares one error detector (`error_d`, parameters n/h) among CH serial input channels.
- Round-robin scheduler:
  - resets the detector between windows;
  - forwards WIN samples from the current channel;
  - captures the detector's warning/error into per-channel sticky status;
  - raises an interrupt that software clears via a valid/ready handshake.
- Sits between the channel inputs and the single `error_d` instance.

Parameters:
- CH, 4, number of monitored channels (2..16)
- WIN, 64, samples per scan window; must equal the detector's n
- FLUSH, 2, cycles det_reset is held high before each window (>=1)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  scanning allowed; sampled each cycle
- ch_in  in  CH  serial data, one bit per channel
- det_in  out  1  sample forwarded to detector `in`
- det_reset  out  1  active-high reset to detector
- det_warning  in  1  detector warning output
- det_error  in  1  detector error output
- cur_ch  out  $clog2(CH)  channel currently owning the detector
- warn_status  out  CH  sticky per-channel warning flags
- err_status  out  CH  sticky per-channel error flags
- irq  out  1  high while any err_status bit set (warn too, if WARN_IRQ set)
- clr_valid  in  1  clear request
- clr_ch  in  $clog2(CH)  channel whose flags to clear
- clr_ready  out  1  clear accepted this cycle
- WARN_IRQ is a parameter: 0 default, 1 = warnings also raise irq

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - state=IDLE, cur_ch=0, det_in=0, det_reset=1;
  - warn_status=0, err_status=0, irq=0, clr_ready=0;
  - window and flush counters = 0.
- FSM states: IDLE, FLUSH, SCAN, CAPTURE, NEXT.
- IDLE:
  - det_reset=1, det_in=0;
  - -> FLUSH when enable=1.
- FLUSH:
  - det_reset=1 for exactly FLUSH cycles, then -> SCAN.
- SCAN:
  - det_reset=0;
  - det_in is registered ch_in[cur_ch], one-cycle latency from ch_in to det_in;
  - stays exactly WIN cycles (counter 0..WIN-1, width $clog2(WIN)), then -> CAPTURE.
- CAPTURE:
  - one cycle, det_reset=0, det_in=0;
  - ORs det_warning into warn_status[cur_ch] and det_error into err_status[cur_ch];
  - -> NEXT.
- NEXT:
  - det_reset=1;
  - cur_ch increments, wrapping CH-1 -> 0 (non-power-of-2 CH wraps explicitly);
  - -> FLUSH if enable=1, else IDLE.
- Per-window period: FLUSH+WIN+2 cycles.
- enable deasserted mid-window: the current window completes through CAPTURE/NEXT, then the block parks in IDLE. No partial-window captures.
- Clear handshake:
  - clr_ready=1 in every cycle except CAPTURE;
  - a clear fires when clr_valid & clr_ready, zeroing warn_status[clr_ch] and err_status[clr_ch] next cycle;
  - clr_ch >= CH: accepted, no effect.
- Same-cycle set vs clear on one channel cannot happen (clr_ready=0 in CAPTURE), so set always wins.
- irq is registered, one cycle after the status change.
- Asynchronous reset mid-window:
  - immediate return to the reset values above;
  - det_reset asserts asynchronously.

Optional Feature:
- Macro: ERR_SCAN_MASK_EN.
- When defined:
  - adds input ch_mask [CH-1:0];
  - NEXT advances to the next channel (wrapping) whose ch_mask bit is 1, searched combinationally over CH positions;
  - if all bits are 0, -> IDLE and stays there until some bit is 1 and enable=1;
  - a masked channel's status flags hold their values.
- When undefined: no ch_mask port; every channel is scanned in order.

Decomposition:
- Package err_scan_pkg:
  - state enum (IDLE, FLUSH, SCAN, CAPTURE, NEXT);
  - default CH/WIN/FLUSH localparams;
  - channel-index width function.
- One sub-module, err_scan_rr_ptr: holds cur_ch and computes the next channel, with masked search under ERR_SCAN_MASK_EN.
- Window/flush counters and the status registers stay in the top.

Test Plan:
- Reset release, enable=1, all ch_in=0, detector model never flags -> cur_ch cycles 0,1,2,3,0 with a 68-cycle period (FLUSH=2, WIN=64); status stays 0; irq stays 0.
- Detector model asserts det_error during channel 2's window -> err_status=4'b0100 after CAPTURE; irq=1 one cycle later; other channels stay clear.
- Same flagged state, clr_valid=1 with clr_ch=2 -> clr_ready=1 handshake; err_status returns to 0; irq drops to 0 on the following cycle.
- enable=0 at sample 30 of channel 1 -> window runs to 64 samples, capture occurs, cur_ch=2, FSM in IDLE with det_reset=1.
- reset low at sample 10 of channel 3 -> det_reset=1 immediately; status=0; cur_ch=0 after release.
- With ERR_SCAN_MASK_EN and ch_mask=4'b1010 -> only channels 1 and 3 are scanned; ch_mask=0 -> IDLE, no further det_reset deassertion.
